// File: rtl/lap_split_fifo.sv
// Lap/split capture FIFO: stages the BCD time and its split on each lap strobe,
// then queues entries for the LCD controller behind a valid/ready interface.
module lap_split_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          lap_trig,
  input  logic [3:0]    minutes,
  input  logic [3:0]    tens,
  input  logic [3:0]    ones,
  input  logic [3:0]    tenths,
  input  logic [3:0]    hundredths,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [19:0]   rd_total,
  output logic [19:0]   rd_split,
  output logic [6:0]    rd_lap,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);

  // Digit-serial BCD subtract; tens-of-seconds wraps at 6, minute borrow is dropped.
  function automatic logic [19:0] bcd_sub(input logic [19:0] a, input logic [19:0] b);
    logic [19:0] d;
    logic        borrow;
    logic [4:0]  diff;
    d      = '0;
    borrow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      diff   = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, borrow};
      borrow = diff[4];
      if (borrow) diff = diff + ((i == 3) ? 5'd6 : 5'd10);
      d[4*i +: 4] = diff[3:0];
    end
    return d;
  endfunction

  logic          stage_valid_reg;
  logic [19:0]   stage_total_reg;
  logic [19:0]   stage_split_reg;
  logic [6:0]    stage_lap_reg;
  logic [19:0]   last_total_reg;
  logic [6:0]    lap_cnt_reg;

  logic [19:0]   mem_total [DEPTH];
  logic [19:0]   mem_split [DEPTH];
  logic [6:0]    mem_lap   [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          rd_valid_reg;
  logic [19:0]   rd_total_reg;
  logic [19:0]   rd_split_reg;
  logic [6:0]    rd_lap_reg;
  logic          overflow_reg;

  logic [19:0]   cur_total;
  logic [19:0]   cur_split;
  logic [6:0]    lap_cnt_next;
  logic          pop;
  logic          push;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   remain;
  logic [AW:0]   level_next;
  logic [19:0]   head_total_next;
  logic [19:0]   head_split_next;
  logic [6:0]    head_lap_next;

  assign cur_total    = {minutes, tens, ones, tenths, hundredths};
  assign cur_split    = bcd_sub(cur_total, last_total_reg);
  assign lap_cnt_next = (lap_cnt_reg >= 7'd99) ? 7'd99 : lap_cnt_reg + 7'd1;

  assign pop         = rd_valid_reg & rd_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push        = stage_valid_reg & ~clr & ((level_reg != FULL_LEVEL) | pop);
  assign rd_ptr_next = rd_ptr_reg + {{(AW-1){1'b0}}, pop};
  assign remain      = level_reg - {{AW{1'b0}}, pop};
  assign level_next  = level_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  // Next head: an older stored entry if one survives the pop, else the entry being pushed.
  always_comb begin
    head_total_next = '0;
    head_split_next = '0;
    head_lap_next   = '0;
    if (remain != '0) begin
      head_total_next = mem_total[rd_ptr_next];
      head_split_next = mem_split[rd_ptr_next];
      head_lap_next   = mem_lap[rd_ptr_next];
    end else if (push) begin
      head_total_next = stage_total_reg;
      head_split_next = stage_split_reg;
      head_lap_next   = stage_lap_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_total[wr_ptr_reg] <= stage_total_reg;
      mem_split[wr_ptr_reg] <= stage_split_reg;
      mem_lap[wr_ptr_reg]   <= stage_lap_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid_reg <= 1'b0;
      stage_total_reg <= '0;
      stage_split_reg <= '0;
      stage_lap_reg   <= '0;
      last_total_reg  <= '0;
      lap_cnt_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      rd_valid_reg    <= 1'b0;
      rd_total_reg    <= '0;
      rd_split_reg    <= '0;
      rd_lap_reg      <= '0;
      overflow_reg    <= 1'b0;
    end else if (clr) begin
      stage_valid_reg <= 1'b0;
      stage_total_reg <= '0;
      stage_split_reg <= '0;
      stage_lap_reg   <= '0;
      last_total_reg  <= '0;
      lap_cnt_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      rd_valid_reg    <= 1'b0;
      rd_total_reg    <= '0;
      rd_split_reg    <= '0;
      rd_lap_reg      <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      stage_valid_reg <= lap_trig;
      if (lap_trig) begin
        stage_total_reg <= cur_total;
        stage_split_reg <= cur_split;
        stage_lap_reg   <= lap_cnt_next;
        last_total_reg  <= cur_total;
        lap_cnt_reg     <= lap_cnt_next;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
      if (stage_valid_reg && !push) overflow_reg <= 1'b1;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      rd_valid_reg <= (level_next != '0);
      rd_total_reg <= head_total_next;
      rd_split_reg <= head_split_next;
      rd_lap_reg   <= head_lap_next;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_total = rd_total_reg;
  assign rd_split = rd_split_reg;
  assign rd_lap   = rd_lap_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_lap_split_fifo.sv
// Bench for lap_split_fifo: directed scenarios plus random traffic against a
// queue-based model that computes splits in plain hundredths-of-a-second arithmetic.
module tb_lap_split_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk_100 = 1'b0;
  logic          reset;
  logic          clr;
  logic          lap_trig;
  logic [3:0]    minutes, tens, ones, tenths, hundredths;
  logic          rd_ready;
  logic          rd_valid;
  logic [19:0]   rd_total;
  logic [19:0]   rd_split;
  logic [6:0]    rd_lap;
  logic [AW:0]   level;
  logic          overflow;

  always #5 clk_100 = ~clk_100;

  lap_split_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk_100),
    .reset      (reset),
    .clr        (clr),
    .lap_trig   (lap_trig),
    .minutes    (minutes),
    .tens       (tens),
    .ones       (ones),
    .tenths     (tenths),
    .hundredths (hundredths),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_total   (rd_total),
    .rd_split   (rd_split),
    .rd_lap     (rd_lap),
    .level      (level),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [19:0] total;
    logic [19:0] split;
    logic [6:0]  lap;
  } entry_t;

  entry_t q[$];
  bit     m_stage_v;
  entry_t m_stage;
  int     m_last;
  int     m_lap;
  bit     m_ovf;
  int     checks = 0;
  int     errors = 0;

  function automatic int to_hund(input logic [19:0] b);
    return b[19:16] * 6000 + b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [19:0] to_bcd(input int h);
    int m, r;
    m = h / 6000;
    r = h % 6000;
    return {4'(m), 4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  function automatic logic [19:0] rand_time();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_stage_v = 1'b0;
    m_stage   = '0;
    m_last    = 0;
    m_lap     = 0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_step();
    bit pop, push;
    int t;
    pop  = (q.size() > 0) && rd_ready;
    push = m_stage_v && !clr && ((q.size() < DEPTH) || pop);
    if (clr) begin
      model_reset();
    end else begin
      if (pop) begin
        $display("pop lap=%0d total=%05h split=%05h", q[0].lap, q[0].total, q[0].split);
        void'(q.pop_front());
      end
      if (push) q.push_back(m_stage);
      else if (m_stage_v) m_ovf = 1'b1;
      if (lap_trig) begin
        t = to_hund({minutes, tens, ones, tenths, hundredths});
        m_lap = (m_lap < 99) ? m_lap + 1 : 99;
        m_stage.total = {minutes, tens, ones, tenths, hundredths};
        m_stage.split = to_bcd((((t - m_last) % 60000) + 60000) % 60000);
        m_stage.lap   = 7'(m_lap);
        m_last    = t;
        m_stage_v = 1'b1;
      end else begin
        m_stage_v = 1'b0;
      end
    end
  endtask

  task automatic compare_outputs();
    entry_t e;
    e = (q.size() > 0) ? q[0] : '0;
    check("valid", rd_valid, q.size() > 0);
    check("level", level, q.size());
    check("overflow", overflow, m_ovf);
    check("total", rd_total, e.total);
    check("split", rd_split, e.split);
    check("lap", rd_lap, e.lap);
  endtask

  // Drive one cycle of inputs after a falling edge, step the model at the rising edge.
  task automatic step(input bit lt, input bit rr, input bit cl, input logic [19:0] tm);
    lap_trig = lt;
    rd_ready = rr;
    clr      = cl;
    {minutes, tens, ones, tenths, hundredths} = tm;
    @(posedge clk_100);
    model_step();
    @(negedge clk_100);
    compare_outputs();
  endtask

  initial begin
    logic [19:0] tl [12];
    reset = 1'b0;
    clr = 1'b0; lap_trig = 1'b0; rd_ready = 1'b0;
    {minutes, tens, ones, tenths, hundredths} = '0;
    model_reset();
    @(negedge clk_100);
    @(negedge clk_100);
    compare_outputs();
    reset = 1'b1;

    // Single lap after reset.
    step(1, 0, 0, 20'h01234);
    step(0, 0, 0, 20'h0);
    check("t1_total", rd_total, 20'h01234);
    check("t1_split", rd_split, 20'h01234);
    check("t1_lap", rd_lap, 7'd1);
    check("t1_level", level, 1);

    // Borrow through tens-of-seconds.
    step(0, 0, 1, 20'h0);
    step(1, 0, 0, 20'h05995);
    step(1, 0, 0, 20'h10002);
    step(0, 1, 0, 20'h0);
    check("t2_split", rd_split, 20'h00007);
    check("t2_lap", rd_lap, 7'd2);

    // Minute wrap on split.
    step(0, 0, 1, 20'h0);
    step(1, 0, 0, 20'h95999);
    step(1, 1, 0, 20'h00005);
    step(0, 1, 0, 20'h0);
    check("wrap_split", rd_split, 20'h00006);

    // Overflow: ten laps into an eight-deep FIFO.
    step(0, 0, 1, 20'h0);
    for (int i = 1; i <= 10; i++) begin
      tl[i] = to_bcd(i * 137);
      step(1, 0, 0, tl[i]);
    end
    step(0, 0, 0, 20'h0);
    check("t3_level", level, DEPTH);
    check("t3_ovf", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check("t3_drain_lap", rd_lap, i);
      step(0, 1, 0, 20'h0);
    end
    tl[11] = to_bcd(2000);
    step(1, 0, 0, tl[11]);
    step(0, 0, 0, 20'h0);
    check("t3_lap11", rd_lap, 7'd11);
    check("t3_split11", rd_split, to_bcd(2000 - 10 * 137));

    // Full FIFO, push coincident with pop.
    step(0, 0, 1, 20'h0);
    for (int i = 1; i <= 9; i++) step(1, 0, 0, to_bcd(i * 211));
    check("t4_full", level, DEPTH);
    step(0, 1, 0, 20'h0);
    check("t4_level", level, DEPTH);
    check("t4_ovf", overflow, 1'b0);

    // Ready toggling with three entries.
    step(0, 0, 1, 20'h0);
    step(1, 0, 0, 20'h00101);
    step(1, 0, 0, 20'h00202);
    step(1, 0, 0, 20'h00303);
    step(0, 0, 0, 20'h0);
    check("t5_level3", level, 3);
    step(0, 1, 0, 20'h0);
    check("t5_level2a", level, 2);
    check("t5_head2a", rd_total, 20'h00202);
    step(0, 0, 0, 20'h0);
    check("t5_level2b", level, 2);
    check("t5_head2b", rd_total, 20'h00202);
    step(0, 1, 0, 20'h0);
    check("t5_level1", level, 1);
    check("t5_head3", rd_total, 20'h00303);

    // Clear with a coincident lap strobe.
    step(0, 0, 1, 20'h0);
    for (int i = 1; i <= 4; i++) step(1, 0, 0, to_bcd(i * 500));
    step(0, 0, 0, 20'h0);
    step(1, 0, 1, 20'h12345);
    check("t6_level", level, 0);
    check("t6_valid", rd_valid, 1'b0);
    check("t6_ovf", overflow, 1'b0);
    step(1, 0, 0, 20'h20517);
    step(0, 0, 0, 20'h0);
    check("t6_lap", rd_lap, 7'd1);
    check("t6_split", rd_split, 20'h20517);

    // Random traffic.
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 2) == 0), $urandom_range(0, 1), ($urandom_range(0, 39) == 0),
           rand_time());

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 4; i++) step(1, 0, 0, rand_time());
    step(0, 1, 0, 20'h0);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", rd_valid, 1'b0);
    check("arst_level", level, 0);
    check("arst_total", rd_total, 20'h0);
    check("arst_split", rd_split, 20'h0);
    check("arst_lap", rd_lap, 7'd0);
    check("arst_ovf", overflow, 1'b0);
    model_reset();
    @(negedge clk_100);
    reset = 1'b1;
    step(1, 0, 0, 20'h00042);
    step(0, 1, 0, 20'h0);
    step(0, 1, 0, 20'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
